// File: rtl/aes_pkg.sv
// Shared AES-128/192/256 encryption definitions: widths, FSM encoding, round-count mapping, GF(2^8) arithmetic.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int STATE_W = 128;      // one AES block
    localparam int ROUND_W = 4;        // holds 0..14; Nr never exceeds 14 so it cannot wrap
    localparam int KS_W    = 1920;     // 60 expanded key words
    localparam int NUM_RK  = 15;       // round keys 0..14

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } fsm_e;

    // Only 128/192/256-bit keys exist; every other word count is rejected.
    function automatic logic nk_is_legal(input logic [7:0] nk);
        return (nk == 8'd4) || (nk == 8'd6) || (nk == 8'd8);
    endfunction

    // Nr = Nk + 6 for the legal key lengths; zero for anything else.
    function automatic logic [ROUND_W-1:0] nr_of_nk(input logic [7:0] nk);
        logic [ROUND_W-1:0] nr;
        case (nk)
            8'd4:    nr = 4'd10;
            8'd6:    nr = 4'd12;
            8'd8:    nr = 4'd14;
            default: nr = 4'd0;
        endcase
        return nr;
    endfunction

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box for one byte: multiplicative inverse in GF(2^8) followed by the affine map.
// Latency: purely combinational.
// Backpressure: none.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_inv;

    // a^254 is the inverse for a != 0 and yields 0 for a == 0, which is what the S-box wants.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] pw;
        logic [7:0] acc;
        pw  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        return acc;
    endfunction

    assign w_inv = gf_inv(i_byte);

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes_cipher.sv
// Iterative FIPS-197 encryption of one block, one round per clock, using an externally expanded key.
// Latency: done rises Nr+2 edges after reset is released (12/14/16 for Nk = 4/6/8).
// Backpressure: none; the result is held with done until the next reset.
module aes_cipher
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           Nk,
    input  logic [STATE_W-1:0]   plainText,
    input  logic [KS_W-1:0]      keySchedule,
    output logic [STATE_W-1:0]   cipherText,
    output logic                 done
);

    fsm_e                 r_fsm;
    fsm_e                 w_fsm_nxt;
    logic [STATE_W-1:0]   r_state;
    logic [ROUND_W-1:0]   r_round;
    logic [ROUND_W-1:0]   r_nr;
    logic                 r_halt;      // illegal key length seen: park in IDLE until reset

    logic [STATE_W-1:0]   w_rk_tab [0:15];
    logic [ROUND_W-1:0]   w_rk_idx;
    logic [STATE_W-1:0]   w_rk;
    logic [STATE_W-1:0]   w_sub;
    logic [STATE_W-1:0]   w_shift;
    logic [STATE_W-1:0]   w_mix;
    logic [STATE_W-1:0]   w_round_out;
    logic [STATE_W-1:0]   w_final_out;
    logic                 w_nk_ok;

    // One column of MixColumns: multiply by the circulant {02 03 01 01}.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return { xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3) };
    endfunction

    // Slice the key schedule into round keys; slot 15 is unreachable padding.
    for (genvar g = 0; g < NUM_RK; g++) begin : g_rk
        assign w_rk_tab[g] = keySchedule[KS_W-1-128*g -: 128];
    end
    assign w_rk_tab[15] = '0;

    // INIT whitens with rk0; ROUND and FINAL use the running round number (which reaches Nr in FINAL).
    assign w_rk_idx = (r_fsm == ST_INIT) ? 4'd0 : r_round;
    assign w_rk     = w_rk_tab[w_rk_idx];
    assign w_nk_ok  = nk_is_legal(Nk);

    // SubBytes: sixteen parallel S-boxes over the state register.
    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (r_state[STATE_W-1-8*g -: 8]),
            .o_byte (w_sub[STATE_W-1-8*g -: 8])
        );
    end

    // ShiftRows: byte k is row k%4, column k/4; row r rotates left by r columns.
    always_comb begin
        w_shift = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[STATE_W-1-8*(r+4*c) -: 8] = w_sub[STATE_W-1-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    // MixColumns over the four 32-bit columns.
    always_comb begin
        w_mix = '0;
        for (int c = 0; c < 4; c++) begin
            w_mix[STATE_W-1-32*c -: 32] = mix_col(w_shift[STATE_W-1-32*c -: 32]);
        end
    end

    // AddRoundKey for a full round and for the last round (which skips MixColumns).
    assign w_round_out = w_mix   ^ w_rk;
    assign w_final_out = w_shift ^ w_rk;

    // Next-state and output decode; the result is gated so no intermediate round state leaks out.
    always_comb begin
        w_fsm_nxt  = r_fsm;
        done       = 1'b0;
        cipherText = '0;
        case (r_fsm)
            ST_IDLE:  if (!r_halt) w_fsm_nxt = ST_INIT;
            ST_INIT:  w_fsm_nxt = w_nk_ok ? ST_ROUND : ST_IDLE;
            ST_ROUND: if (r_round == r_nr - 4'd1) w_fsm_nxt = ST_FINAL;
            ST_FINAL: w_fsm_nxt = ST_DONE;
            ST_DONE: begin
                done       = 1'b1;
                cipherText = r_state;
            end
            default:  w_fsm_nxt = ST_IDLE;
        endcase
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Datapath: load whitened block in INIT, then one round per cycle; frozen in IDLE and DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '0;
            r_round <= '0;
            r_nr    <= '0;
            r_halt  <= 1'b0;
        end else begin
            case (r_fsm)
                ST_INIT: begin
                    if (w_nk_ok) begin
                        r_state <= plainText ^ w_rk;
                        r_round <= 4'd1;
                        r_nr    <= nr_of_nk(Nk);
                    end else begin
                        r_halt  <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    r_state <= w_round_out;
                    r_round <= r_round + 4'd1;
                end
                ST_FINAL: begin
                    r_state <= w_final_out;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher.sv
// Directed bench for aes_cipher: FIPS-197 vectors for all key lengths, abort/restart, illegal Nk.
// Latency: checks done arrives exactly Nr+2 edges after reset release.
// Backpressure: n/a.
module tb_aes_cipher;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    Nk = 8'd4;
    logic [127:0]  plainText = '0;
    logic [1919:0] keySchedule = '0;
    logic [127:0]  cipherText;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbox_t  [0:255];
    logic [7:0] isbox_t [0:255];

    typedef struct {
        int           nk;
        logic [127:0] ct;
        int           edges;
    } vec_t;

    vec_t vecs [0:2];
    int   bad_nk [0:2];

    always #5 clk = ~clk;

    aes_cipher dut (
        .clk         (clk),
        .reset       (reset),
        .Nk          (Nk),
        .plainText   (plainText),
        .keySchedule (keySchedule),
        .cipherText  (cipherText),
        .done        (done)
    );

    // ---------------- reference arithmetic (independent of the RTL package) ----------------
    function automatic logic [7:0] tb_xt(input logic [7:0] a);
        logic [7:0] s;
        s = a << 1;
        return a[7] ? (s ^ 8'h1b) : s;
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = tb_xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic init_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x]  = s;
            isbox_t[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Key bytes 00,01,02,... expanded per FIPS-197; unused trailing words are zero.
    function automatic logic [1919:0] build_ks(input int nk);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ks;
        int            total;
        total = 4 * (nk + 7);
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = tb_xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 60; i++) ks[1919-32*i -: 32] = w[i];
        return ks;
    endfunction

    // Inverse cipher used for the loopback check.
    function automatic logic [127:0] decipher(input logic [127:0] ct, input logic [1919:0] ks, input int nr);
        logic [7:0]   s [0:15];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] v;
        v = ct ^ ks[1919-128*nr -: 128];
        for (int r = nr - 1; r >= 0; r--) begin
            for (int k = 0; k < 16; k++) s[k] = v[127-8*k -: 8];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    v[127-8*(row+4*c) -: 8] = isbox_t[s[row+4*((c-row+4)%4)]];
            v = v ^ ks[1919-128*r -: 128];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = v[127-32*c -: 32];
                    v[127-32*c -: 32] = {
                        tb_mul(a0,8'd14) ^ tb_mul(a1,8'd11) ^ tb_mul(a2,8'd13) ^ tb_mul(a3,8'd9),
                        tb_mul(a0,8'd9)  ^ tb_mul(a1,8'd14) ^ tb_mul(a2,8'd11) ^ tb_mul(a3,8'd13),
                        tb_mul(a0,8'd13) ^ tb_mul(a1,8'd9)  ^ tb_mul(a2,8'd14) ^ tb_mul(a3,8'd11),
                        tb_mul(a0,8'd11) ^ tb_mul(a1,8'd13) ^ tb_mul(a2,8'd9)  ^ tb_mul(a3,8'd14)};
                end
            end
        end
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Hold reset for two edges with the given operands, check idle outputs, release on a falling edge.
    task automatic start_run(input int nk, input logic [1919:0] ks, input string tag);
        @(negedge clk);
        reset = 1'b1;
        Nk = 8'(nk);
        plainText = PT;
        keySchedule = ks;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_int({tag, "_reset_done"}, int'(done), 0);
        check128({tag, "_reset_ct"}, cipherText, '0);
        reset = 1'b0;
    endtask

    // Count edges until done (bounded); flag any non-zero output before done; optionally
    // disturb Nk/plainText after a given edge to show they are only sampled in INIT.
    task automatic run_to_done(input int scramble_at, output int edges, output int leak);
        edges = 0;
        leak  = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done === 1'b1) break;
            if (cipherText !== '0) leak = 1;
            if (edges == scramble_at) begin
                plainText = ~PT;
                Nk = 8'd6;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int            edges, leak, bad;
        logic [1919:0] ks;

        init_tables();

        vecs[0] = '{nk: 4, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, edges: 12};
        vecs[1] = '{nk: 6, ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191, edges: 14};
        vecs[2] = '{nk: 8, ct: 128'h8ea2b7ca516745bfeafc49904b496089, edges: 16};
        bad_nk[0] = 5;
        bad_nk[1] = 0;
        bad_nk[2] = 12;

        // Known-answer runs for each key length, with loopback and result hold.
        for (int i = 0; i < 3; i++) begin
            ks = build_ks(vecs[i].nk);
            start_run(vecs[i].nk, ks, $sformatf("kat%0d", vecs[i].nk));
            run_to_done(0, edges, leak);
            check_int($sformatf("kat%0d_edges", vecs[i].nk), edges, vecs[i].edges);
            check128($sformatf("kat%0d_ct", vecs[i].nk), cipherText, vecs[i].ct);
            check_int($sformatf("kat%0d_no_leak", vecs[i].nk), leak, 0);
            check128($sformatf("kat%0d_loopback", vecs[i].nk), decipher(cipherText, ks, vecs[i].nk + 6), PT);
            plainText = ~PT;
            Nk = 8'd8;
            repeat (5) @(negedge clk);
            check_int($sformatf("kat%0d_hold_done", vecs[i].nk), int'(done), 1);
            check128($sformatf("kat%0d_hold_ct", vecs[i].nk), cipherText, vecs[i].ct);
        end

        // Abort mid-run with reset at edge 6, then restart; inputs disturbed after INIT of the re-run.
        ks = build_ks(4);
        start_run(4, ks, "abort");
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_int("abort_done", int'(done), 0);
        check128("abort_ct", cipherText, '0);
        reset = 1'b0;
        run_to_done(2, edges, leak);
        check_int("abort_rerun_edges", edges, 12);
        check128("abort_rerun_ct", cipherText, vecs[0].ct);

        // Illegal key lengths park the block: nothing ever appears on the outputs.
        for (int i = 0; i < 3; i++) begin
            start_run(bad_nk[i], ks, $sformatf("bad%0d", bad_nk[i]));
            bad = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (done !== 1'b0 || cipherText !== '0) bad = 1;
            end
            check_int($sformatf("bad%0d_hold_idle", bad_nk[i]), bad, 0);
        end

        // A reset clears the parked state and a legal run works again.
        start_run(4, ks, "recover");
        run_to_done(0, edges, leak);
        check_int("recover_edges", edges, 12);
        check128("recover_ct", cipherText, vecs[0].ct);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_cipher.md
AES_CIPHER -- requirements
Module: aes_cipher

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high; while high, the block is held idle.
REQ-003 SHALL have port Nk, input, 8 bits: key length in 32-bit words; legal values 4, 6, 8.
REQ-004 SHALL have port plainText, input, 128 bits: block to encrypt; bit 127 is state byte 0, MSB.
REQ-005 SHALL have port keySchedule, input, 1920 bits: expanded key words w[0..59]; w[i] = keySchedule[1919-32*i -: 32]; round key r = keySchedule[1919-128*r -: 128].
REQ-006 SHALL have port cipherText, output, 128 bits: encrypted block, same byte order as plainText.
REQ-007 SHALL have port done, output, 1 bit: high once cipherText is final.

Function
REQ-008 SHALL compute Nr = Nk+6 (10/12/14) and perform FIPS-197 encryption, one round per clock.
REQ-009 SHALL implement states IDLE, INIT, ROUND, FINAL, DONE; reset forces IDLE.
REQ-010 SHALL move IDLE -> INIT on the first rising edge with reset low.
REQ-011 In INIT, SHALL sample Nk and plainText, load state = plainText XOR rk0, and set round = 1.
REQ-012 SHALL check Nk in INIT; an illegal Nk SHALL go to IDLE-hold: done stays 0, cipherText stays 0 until reset.
REQ-013 In ROUND, SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey(rk[round]) each cycle; round increments; move to FINAL when round == Nr-1 completes.
REQ-014 In FINAL, SHALL apply SubBytes, ShiftRows and AddRoundKey(rk[Nr]) without MixColumns, then enter DONE.
REQ-015 In DONE, SHALL drive cipherText = state and done = 1, holding both until reset; no further state updates.
REQ-016 SHALL assert done exactly Nr+2 rising edges after the first edge with reset low (12/14/16 for Nk = 4/6/8).
REQ-017 SHALL keep cipherText at 0 whenever done = 0; no intermediate round state SHALL be visible.
REQ-018 SHALL read keySchedule combinationally every round; it SHALL be stable from INIT through FINAL (system contract, not checked).
REQ-019 SHALL use a round counter of 4 bits, with no wrap possible for Nr ≤ 14.
REQ-020 Reset asserted mid-encryption SHALL abort: the next edge yields IDLE, done = 0, cipherText = 0; a new run begins on deassertion.

Reset
REQ-021 On reset, SHALL set state register = 0, round = 0, FSM = IDLE, cipherText = 0 and done = 0, all synchronously.
REQ-022 SHALL ignore Nk and plainText while reset is high.

Structure
REQ-023 SHALL place the Nr mapping, state and round-counter widths, the FSM encoding, and the xtime/GF(2^8) helper function in shared package aes_pkg.
REQ-024 SHALL instantiate sub-module aes_sbox (combinational 8-bit forward S-box) 16 times for SubBytes.
REQ-025 SHALL implement ShiftRows, MixColumns and AddRoundKey as combinational logic inside aes_cipher, with a single 128-bit state register.

Verification
REQ-026 Nk=4, plainText=00112233445566778899aabbccddeeff, key 000102…0f expanded -> done after 12 edges, cipherText=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-027 Nk=6, same plainText, key 000102…17 -> done after 14 edges, cipherText=dda97ca4864cdfe06eaf70a0ec0d7191.
REQ-028 Nk=8, same plainText, key 000102…1f -> done after 16 edges, cipherText=8ea2b7ca516745bfeafc49904b496089.
REQ-029 Nk=4 run with reset reasserted at edge 6, then released -> done and cipherText are 0 during reset; the re-run gives 69c4e0d8… after 12 further edges.
REQ-030 Nk=5 -> done stays 0 and cipherText stays 0 for 30 cycles.
REQ-031 Loopback: aes_cipher output into Decipher with the same keySchedule, all three Nk -> Decipher output equals 00112233445566778899aabbccddeeff.
